// File: rtl/rle_pixel_decoder.sv
// rle_pixel_decoder: parses a 2-byte RLE stream into a pending slot and emits pixels to the sync generator.
module rle_pixel_decoder #(
  parameter int STALL_W = 16
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               activevideo,
  input  logic               frame_start,
  output logic               data_done,
  output logic [5:0]         rgb,
  output logic               sync_err,
  output logic [STALL_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, EMIT, WAIT_FRAME} state_t;
  state_t state, state_nx;
  logic phase, pend_valid, pend_mark;
  logic [7:0] run_hold, pend_n, run_cnt;
  logic [5:0] pend_col, colour;
  logic accept, consume, run_end, load;
  always_ff @(posedge px_clk)
    if (reset) state <= WAIT_FRAME;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == EMPTY && pend_valid) state_nx = pend_mark ? WAIT_FRAME : EMIT;
    else if (run_end) state_nx = !pend_valid ? EMPTY : pend_mark ? WAIT_FRAME : EMIT;
    else if (state == WAIT_FRAME && frame_start) state_nx = EMPTY;
  end
  always_comb begin
    in_ready  = !pend_valid;
    accept    = in_valid && in_ready;
    consume   = activevideo && (state == EMIT || state == WAIT_FRAME);
    data_done = !activevideo || state == EMIT || state == WAIT_FRAME;
    run_end   = consume && state == EMIT && run_cnt == 8'd0;
    load      = pend_valid && (state == EMPTY || run_end);
  end
  // accept and load are mutually exclusive since in_ready is low while the slot is full
  always_ff @(posedge px_clk) begin
    if (reset) begin
      phase      <= 1'b0;
      pend_valid <= 1'b0;
      pend_mark  <= 1'b0;
      pend_n     <= 8'd0;
      pend_col   <= 6'd0;
      run_hold   <= 8'd0;
      run_cnt    <= 8'd0;
      colour     <= 6'd0;
      rgb        <= 6'd0;
      sync_err   <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (accept) begin
        phase <= !phase;
        if (!phase) run_hold <= in_data;
        else begin
          {pend_n, pend_col, pend_mark} <= {run_hold, in_data[5:0], in_data[7:6] == 2'b11};
          pend_valid <= 1'b1;
        end
      end else if (load) pend_valid <= 1'b0;
      if (load) begin
        run_cnt <= pend_n;
        colour  <= pend_col;
      end else if (consume && state == EMIT) run_cnt <= run_cnt - 8'd1;
      rgb <= !activevideo ? 6'd0 : state == EMIT ? colour : state == WAIT_FRAME ? 6'd0 : rgb;
      if (frame_start && state != WAIT_FRAME) sync_err <= 1'b1;
      if (activevideo && !data_done && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
endmodule

// File: tb/tb_rle_pixel_decoder.sv
// tb_rle_pixel_decoder: directed scenario tests for the RLE pixel decoder.
module tb_rle_pixel_decoder;
  logic       px_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       activevideo = 1'b0;
  logic       frame_start = 1'b0;
  logic       data_done;
  logic [5:0] rgb;
  logic       sync_err;
  logic [3:0] stall_cnt;
  int checks = 0;
  int errors = 0;

  rle_pixel_decoder #(.STALL_W(4)) dut (
    .px_clk(px_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .activevideo(activevideo), .frame_start(frame_start),
    .data_done(data_done), .rgb(rgb), .sync_err(sync_err), .stall_cnt(stall_cnt)
  );

  always #5 px_clk = ~px_clk;

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; activevideo = 1'b0; frame_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, data_done, rgb, sync_err, stall_cnt} !== {1'b1, 1'b1, 6'h00, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b dd=%b rgb=%h err=%b stall=%h exp rdy=1 dd=1 rgb=00 err=0 stall=0",
               in_ready, data_done, rgb, sync_err, stall_cnt);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b exp 1", b, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic_stream();
    logic [5:0] exp_rgb [5] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h01};
    do_reset(); pulse_frame();
    send_byte(8'h03); send_byte(8'h3F); tick();
    send_byte(8'h00); send_byte(8'h01);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_slot_full in_ready=%b exp 0", in_ready); end
    activevideo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rgb !== exp_rgb[i]) begin errors++; $display("FAIL basic_rgb%0d got %h exp %h", i, rgb, exp_rgb[i]); end
    end
    checks++;
    if (data_done !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_underflow dd=%b stall=%0d exp dd=0 stall=0", data_done, stall_cnt);
    end
    tick(); tick();
    checks++;
    if (rgb !== 6'h01 || stall_cnt !== 4'd2) begin
      errors++; $display("FAIL basic_stall rgb=%h stall=%0d exp rgb=01 stall=2", rgb, stall_cnt);
    end
    repeat (20) tick();
    checks++;
    if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_saturate got %h exp f", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_rgb [3] = '{6'h0C, 6'h30, 6'h30};
    do_reset(); pulse_frame();
    send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h01); send_byte(8'h30);
    activevideo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_done !== 1'b1) begin errors++; $display("FAIL b2b_dd%0d got %b exp 1", i, data_done); end
      tick();
      checks++;
      if (rgb !== exp_rgb[i]) begin errors++; $display("FAIL b2b_rgb%0d got %h exp %h", i, rgb, exp_rgb[i]); end
    end
  endtask

  task automatic test_blanking();
    do_reset(); pulse_frame();
    send_byte(8'h02); send_byte(8'h2A); tick();
    activevideo = 1'b1; tick();
    checks++;
    if (rgb !== 6'h2A) begin errors++; $display("FAIL blank_first got %h exp 2a", rgb); end
    activevideo = 1'b0; tick(); tick();
    checks++;
    if (rgb !== 6'h00 || data_done !== 1'b1) begin
      errors++; $display("FAIL blank_off rgb=%h dd=%b exp rgb=00 dd=1", rgb, data_done);
    end
    activevideo = 1'b1; tick();
    checks++;
    if (rgb !== 6'h2A || data_done !== 1'b1) begin
      errors++; $display("FAIL blank_resume1 rgb=%h dd=%b exp rgb=2a dd=1", rgb, data_done);
    end
    tick();
    checks++;
    if (rgb !== 6'h2A || data_done !== 1'b0) begin
      errors++; $display("FAIL blank_resume2 rgb=%h dd=%b exp rgb=2a dd=0", rgb, data_done);
    end
  endtask

  task automatic test_marker();
    do_reset(); pulse_frame();
    send_byte(8'h00); send_byte(8'h07);
    send_byte(8'h00); send_byte(8'hC0);
    activevideo = 1'b1; tick();
    checks++;
    if (rgb !== 6'h07) begin errors++; $display("FAIL marker_pix got %h exp 07", rgb); end
    tick();
    checks++;
    if (rgb !== 6'h00 || data_done !== 1'b1) begin
      errors++; $display("FAIL marker_black rgb=%h dd=%b exp rgb=00 dd=1", rgb, data_done);
    end
    send_byte(8'h00); send_byte(8'h11);
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0 || data_done !== 1'b1 || rgb !== 6'h00) begin
      errors++; $display("FAIL marker_hold rdy=%b dd=%b rgb=%h exp rdy=0 dd=1 rgb=00", in_ready, data_done, rgb);
    end
    pulse_frame();
    checks++;
    if (data_done !== 1'b0 || sync_err !== 1'b0) begin
      errors++; $display("FAIL marker_empty dd=%b err=%b exp dd=0 err=0", data_done, sync_err);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || data_done !== 1'b1) begin
      errors++; $display("FAIL marker_load rdy=%b dd=%b exp rdy=1 dd=1", in_ready, data_done);
    end
    tick();
    checks++;
    if (rgb !== 6'h11) begin errors++; $display("FAIL marker_next got %h exp 11", rgb); end
  endtask

  task automatic test_sync_err();
    do_reset(); pulse_frame();
    send_byte(8'h01); send_byte(8'h05); tick();
    pulse_frame();
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set got %b exp 1", sync_err); end
    activevideo = 1'b1; tick();
    checks++;
    if (rgb !== 6'h05) begin errors++; $display("FAIL sync_pix0 got %h exp 05", rgb); end
    tick();
    checks++;
    if (rgb !== 6'h05) begin errors++; $display("FAIL sync_pix1 got %h exp 05", rgb); end
    tick();
    checks++;
    if (data_done !== 1'b0 || sync_err !== 1'b1) begin
      errors++; $display("FAIL sync_sticky dd=%b err=%b exp dd=0 err=1", data_done, sync_err);
    end
    do_reset();
  endtask

  task automatic test_partial_reset();
    do_reset(); pulse_frame();
    send_byte(8'h05);
    do_reset(); pulse_frame();
    send_byte(8'h00); send_byte(8'h15); tick();
    activevideo = 1'b1; tick();
    checks++;
    if (rgb !== 6'h15 || data_done !== 1'b0) begin
      errors++; $display("FAIL partial_pkt rgb=%h dd=%b exp rgb=15 dd=0", rgb, data_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_back_to_back();
    test_blanking();
    test_marker();
    test_sync_err();
    test_partial_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
